// File: rtl/i2c_bus_capture.sv
// Passive I2C observer: synchronizes SCL/SDA, decodes START/RSTART/STOP/BYTE
// events and queues them in a first-word fall-through FIFO for a consumer.
module i2c_bus_capture #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic       clr_i,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [1:0] evt_type_o,
    output logic [7:0] evt_data_o,
    output logic       evt_ack_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic       trunc_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {EV_START = 2'd0, EV_RSTART = 2'd1, EV_STOP = 2'd2, EV_BYTE = 2'd3} evt_e;
    typedef struct packed {
        evt_e       typ;
        logic [7:0] data;
        logic       ack;
    } evt_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_dly_q, sda_dly_q;
    logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d, bit_q, bit_d;
    logic       busy_q, busy_d, hi_bit_q, hi_bit_d, ovf_q, ovf_d, trunc_q, trunc_d;
    logic [3:0] bit_cnt_q, bit_cnt_d, pending;
    logic [7:0] shift_q, shift_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    evt_t mem_q [FIFO_DEPTH];
    evt_t push_evt, head;
    logic scl_s, sda_s, scl_hi_both;
    logic push, do_write, pop, full, empty, trunc_set;

    assign scl_s       = scl_sync_q[SYNC_STAGES-1];
    assign sda_s       = sda_sync_q[SYNC_STAGES-1];
    assign scl_hi_both = scl_s & scl_dly_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop         = ~empty & evt_ready_i;
    assign head        = mem_q[rd_ptr_q[AW-1:0]];

    // A START/STOP always follows an SCL rise in the same high phase; that rise
    // sampled no data bit, so it is excluded when judging a partial byte.
    assign pending = bit_cnt_q - {3'b000, hi_bit_q};

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        rise_d     = scl_s & ~scl_dly_q;
        fall_d     = ~scl_s & scl_dly_q;
        start_d    = scl_hi_both & sda_dly_q & ~sda_s;
        stop_d     = scl_hi_both & ~sda_dly_q & sda_s;
        bit_d      = sda_s;

        busy_d    = busy_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hi_bit_d  = hi_bit_q;
        push      = 1'b0;
        push_evt  = '0;
        trunc_set = 1'b0;

        if (fall_q) hi_bit_d = 1'b0;
        if (start_q || stop_q) begin
            trunc_set    = (pending != 4'd0);
            push         = 1'b1;
            push_evt.typ = stop_q ? EV_STOP : (busy_q ? EV_RSTART : EV_START);
            busy_d       = start_q;
            bit_cnt_d    = 4'd0;
            hi_bit_d     = 1'b0;
        end else if (rise_q && busy_q) begin
            hi_bit_d = 1'b1;
            if (bit_cnt_q == 4'd8) begin
                push          = 1'b1;
                push_evt.typ  = EV_BYTE;
                push_evt.data = shift_q;
                push_evt.ack  = ~bit_q;
                bit_cnt_d     = 4'd0;
            end else begin
                shift_d   = {shift_q[6:0], bit_q};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end

        do_write = push & (~full | pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_write};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        ovf_d    = (push & full & ~pop) | (ovf_q & ~clr_i);
        trunc_d  = trunc_set | (trunc_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            bit_q      <= 1'b1;
            busy_q     <= 1'b0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            hi_bit_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_s;
            sda_dly_q  <= sda_s;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hi_bit_q   <= hi_bit_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            trunc_q    <= trunc_d;
        end
    end

    // Storage needs no reset: outputs are gated by the pointers.
    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= push_evt;
    end

    assign evt_valid_o = ~empty;
    assign evt_type_o  = empty ? 2'd0 : head.typ;
    assign evt_data_o  = empty ? 8'd0 : head.data;
    assign evt_ack_o   = empty ? 1'b0 : head.ack;
    assign busy_o      = busy_q;
    assign overflow_o  = ovf_q;
    assign trunc_o     = trunc_q;
endmodule

// File: tb/tb_i2c_bus_capture.sv
// Directed bench for i2c_bus_capture: drives I2C bus sequences and checks the
// popped event stream and flags against an event-level queue model.
module tb_i2c_bus_capture;
    localparam int DEPTH = 8;
    localparam int A_NONE = 0, A_START = 1, A_STOP = 2, A_BYTE = 3;

    logic clk = 0, rst = 1, scl_i = 1, sda_i = 1, clr_i = 0, evt_ready_i = 1;
    logic evt_valid_o, evt_ack_o, busy_o, overflow_o, trunc_o;
    logic [1:0] evt_type_o;
    logic [7:0] evt_data_o;

    i2c_bus_capture #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .clr_i(clr_i),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_type_o(evt_type_o),
        .evt_data_o(evt_data_o), .evt_ack_o(evt_ack_o), .busy_o(busy_o),
        .overflow_o(overflow_o), .trunc_o(trunc_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int exp_q[$];   // packed {type, data, ack}
    int log_q[$];   // what the DUT actually delivered
    bit m_busy = 0, m_ovf = 0, m_trunc = 0;
    int m_bits = 0;
    logic [7:0] cur_data;
    bit cur_ack;

    function automatic int pk(int t, int d, int a);
        return (t << 9) | ((d & 8'hFF) << 1) | (a & 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(int e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else m_ovf = 1;
    endfunction

    function automatic void m_apply(int act);
        case (act)
            A_START: begin
                if (m_bits != 0) m_trunc = 1;
                m_push(pk(m_busy ? 1 : 0, 0, 0));
                m_busy = 1; m_bits = 0;
            end
            A_STOP: begin
                if (m_bits != 0) m_trunc = 1;
                m_push(pk(2, 0, 0));
                m_busy = 0; m_bits = 0;
            end
            A_BYTE: m_push(pk(3, cur_data, cur_ack));
            default: ;
        endcase
    endfunction

    // Pins change on a falling edge; the model takes effect just after the
    // fourth rising edge, when the DUT has written the event.
    task automatic drive(bit s, bit d, int act, bit pulse_rdy = 0);
        @(negedge clk); scl_i = s; sda_i = d;
        repeat (3) @(posedge clk);
        #1; if (pulse_rdy) evt_ready_i = 1;
        @(posedge clk);
        #1; if (pulse_rdy) evt_ready_i = 0;
        m_apply(act);
        @(posedge clk);
    endtask

    task automatic scl_set(bit s);
        drive(s, sda_i, A_NONE);
    endtask
    task automatic sda_set(bit b, int act = A_NONE, bit pulse_rdy = 0);
        drive(scl_i, b, act, pulse_rdy);
    endtask
    task automatic bit_clk(bit b, int act);
        scl_set(0); sda_set(b); drive(1, b, act);
    endtask
    task automatic i2c_start();
        if (scl_i == 0) begin sda_set(1); scl_set(1); end
        sda_set(0, A_START);
    endtask
    task automatic i2c_stop(bit pulse_rdy = 0);
        if (scl_i == 1) scl_set(0);
        sda_set(0); scl_set(1);
        sda_set(1, A_STOP, pulse_rdy);
    endtask
    task automatic i2c_byte(logic [7:0] d, bit a);
        cur_data = d; cur_ack = a;
        for (int i = 7; i >= 0; i--) bit_clk(d[i], A_NONE);
        bit_clk(!a, A_BYTE);
        scl_set(0);
    endtask
    task automatic i2c_partial(int n, logic [7:0] d);
        for (int i = 0; i < n; i++) bit_clk(d[7-i], A_NONE);
        m_bits = n;
    endtask
    task automatic set_ready(bit r);
        @(posedge clk); #1 evt_ready_i = r;
    endtask
    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain_complete", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("evt_valid", evt_valid_o, exp_q.size() != 0);
            if (evt_valid_o && exp_q.size() != 0)
                chk("evt_head", pk(evt_type_o, evt_data_o, evt_ack_o), exp_q[0]);
            else if (!evt_valid_o)
                chk("evt_idle_zero", {evt_type_o, evt_data_o, evt_ack_o}, 0);
            chk("busy", busy_o, m_busy);
            chk("overflow", overflow_o, m_ovf);
            chk("trunc", trunc_o, m_trunc);
            if (evt_valid_o && evt_ready_i) begin
                log_q.push_back(pk(evt_type_o, evt_data_o, evt_ack_o));
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {evt_valid_o, evt_type_o, evt_data_o, evt_ack_o, busy_o, overflow_o, trunc_o}, 0);
        rst = 0;
        repeat (3) @(posedge clk);

        // START, 0xA4 ACK, STOP
        i2c_start();
        chk("busy_after_start", busy_o, 1);
        i2c_byte(8'hA4, 1);
        i2c_stop();
        drain();
        chk("t1_busy_end", busy_o, 0);
        chk("t1_flags", {overflow_o, trunc_o}, 0);
        chk("t1_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_start", log_q[0], 0);
            chk("t1_byte", log_q[1], 32'h749);
            chk("t1_stop", log_q[2], 32'h400);
        end

        // START, 0x91 NACK, RSTART, 0x3C ACK, STOP
        log_q.delete();
        i2c_start(); i2c_byte(8'h91, 0);
        i2c_start(); i2c_byte(8'h3C, 1);
        i2c_stop();
        drain();
        chk("t2_count", log_q.size(), 5);
        if (log_q.size() == 5) begin
            chk("t2_nack_byte", log_q[1], 32'h722);
            chk("t2_rstart", log_q[2], 32'h200);
            chk("t2_ack_byte", log_q[3], 32'h679);
        end

        // Overflow: 12 events with consumer stalled
        log_q.delete();
        set_ready(0);
        i2c_start();
        for (int i = 0; i < 10; i++) i2c_byte(8'h10 + i[7:0], i[0]);
        i2c_stop();
        chk("t3_overflow_set", overflow_o, 1);
        chk("t3_valid_held", evt_valid_o, 1);
        set_ready(1);
        drain();
        chk("t3_count", log_q.size(), 8);
        if (log_q.size() == 8) chk("t3_last_kept", log_q[7], pk(3, 8'h16, 0));
        @(negedge clk); clr_i = 1;
        @(posedge clk); #1 clr_i = 0; m_ovf = 0; m_trunc = 0;
        @(posedge clk); #1 chk("t3_overflow_clr", overflow_o, 0);

        // STOP after 5 data bits
        log_q.delete();
        i2c_start();
        i2c_partial(5, 8'hB7);
        i2c_stop();
        drain();
        chk("t4_trunc", trunc_o, 1);
        chk("t4_busy", busy_o, 0);
        chk("t4_events", log_q.size(), 2);
        if (log_q.size() == 2) chk("t4_stop", log_q[1], 32'h400);

        // Full FIFO with simultaneous push and pop
        log_q.delete();
        set_ready(0);
        i2c_start();
        for (int i = 0; i < 7; i++) i2c_byte(8'hC0 + i[7:0], 1);
        i2c_stop(1);
        chk("t5_no_overflow", overflow_o, 0);
        chk("t5_valid", evt_valid_o, 1);
        set_ready(1);
        drain();
        chk("t5_count", log_q.size(), 9);
        if (log_q.size() == 9) chk("t5_tail_stop", log_q[8], 32'h400);

        // Reset in the middle of a byte
        i2c_start();
        i2c_partial(4, 8'hF0);
        scl_set(0);
        @(posedge clk); #1 rst = 1;
        exp_q.delete(); m_busy = 0; m_ovf = 0; m_trunc = 0; m_bits = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_outputs", {evt_valid_o, evt_type_o, evt_data_o, evt_ack_o, busy_o, overflow_o, trunc_o}, 0);
        @(posedge clk); #1 rst = 0;
        sda_set(1); scl_set(1);
        log_q.delete();
        i2c_start(); i2c_byte(8'h55, 1); i2c_stop();
        drain();
        chk("t6_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t6_start", log_q[0], 0);
            chk("t6_byte", log_q[1], 32'h6AB);
        end
        chk("t6_trunc", trunc_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_bus_capture.md
# i2c_bus_capture

Synthesizable passive I2C bus observer sitting between the raw SCL/SDA wires and the I2C monitor of the verification environment. It synchronizes the open-drain lines, detects START, repeated START and STOP conditions, assembles 8-bit bytes plus the 9th (ACK) bit, and queues each event in a small FIFO. The monitor pops fully decoded bus events with a valid/ready handshake instead of sampling pins itself.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, flip-flop stages on each of scl_i and sda_i; ≥2
- clk  input  1  sole clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- scl_i  input  1  raw SCL wire level (asynchronous)
- sda_i  input  1  raw SDA wire level (asynchronous)
- clr_i  input  1  one-cycle pulse; clears overflow_o and trunc_o
- evt_valid_o  output  1  FIFO head holds an event
- evt_ready_i  input  1  consumer accepts head this cycle
- evt_type_o  output  2  0=START, 1=RSTART, 2=STOP, 3=BYTE
- evt_data_o  output  8  byte value, MSB first on the bus; 0 for non-BYTE events
- evt_ack_o  output  1  BYTE only: 1 when 9th bit sampled low (ACK); 0 otherwise
- busy_o  output  1  1 between START and STOP
- overflow_o  output  1  sticky: event dropped because FIFO full
- trunc_o  output  1  sticky: START/STOP arrived with a partial byte pending

## Operation
- Synchronizers reset to 1 (idle bus); edge detector compares last sync stage with a delay register that also resets to 1, so reset never creates an edge.
- START: SDA falls while SCL high. busy_o=0 → push START, busy_o←1; busy_o=1 → push RSTART. bit_cnt←0.
- STOP: SDA rises while SCL high. Push STOP, busy_o←0, bit_cnt←0. STOP while busy_o=0 is still pushed.
- Bit capture only while busy_o=1, on SCL rising edge: bit_cnt 0–7 shift SDA into shift register (MSB first); bit_cnt 8 samples ACK (ack=~SDA), push BYTE{shift, ack}, bit_cnt←0.
- SDA edges while SCL low are data transitions and ignored. SCL edges while busy_o=0 ignored.
- START/STOP with bit_cnt≠0: partial byte discarded (no BYTE event), trunc_o←1, then the START/RSTART/STOP is pushed normally.
- SCL rise and qualifying SDA edge in the same cycle: treat as SCL rise only (SDA treated as stable in that sample).
- FIFO: push when full and no pop in same cycle → event dropped, overflow_o←1. Push and pop same cycle when full → both performed, no overflow. Pop on evt_valid_o & evt_ready_i. evt_* outputs show the head entry (first-word fall-through); undefined content when evt_valid_o=0 is not allowed: drive 0.
- clr_i clears sticky flags; if a set condition occurs in the same cycle, set wins.
- Reset (any time, including mid-byte): FIFO emptied, bit_cnt=0, busy_o=0, shift=0, all flags 0. A byte in progress is lost with no event; the next START is reported as START.

## Timing
- Reset values: evt_valid_o=0, evt_type_o=0, evt_data_o=0, evt_ack_o=0, busy_o=0, overflow_o=0, trunc_o=0.
- Latency: pin change first sampled at clk edge N → edge detected at N+SYNC_STAGES → FIFO write and evt_valid_o=1 (if empty), busy_o/flag update at edge N+SYNC_STAGES+1.
- Throughput: one push and one pop per cycle.
- Input requirement: SCL high and low phases and SDA setup/hold relative to SCL each ≥ SYNC_STAGES+1 clk periods; no glitch filter.

## Test plan
- START, 0xA4 with SDA low on 9th clock, STOP, evt_ready_i=1 → START; BYTE data=0xA4 ack=1; STOP; busy_o 1 then 0; flags 0.
- START, 0x91 NACK, RSTART, 0x3C ACK, STOP → START, BYTE(0x91,0), RSTART, BYTE(0x3C,1), STOP.
- evt_ready_i=0, drive 12 events (START + 10 bytes + STOP) → exactly 8 stored in order, overflow_o=1; drain gives first 8; clr_i pulse → overflow_o=0.
- STOP after 5 data bits → no BYTE, STOP pushed, trunc_o=1, busy_o=0.
- FIFO full, push and pop in the same cycle → count stays 8, overflow_o stays 0, new event appears at tail.
- rst asserted after 4 bits of a byte, released, then START,0x55 ACK,STOP → outputs at reset values during rst; afterward START, BYTE(0x55,1), STOP with no trace of the aborted byte.
